vga_frame_monitor: RTL
======================

VGA_FRAME_MONITOR -- requirements
Module: vga_frame_monitor

Interface
REQ-001 SHALL have parameters: H_TOTAL 800 (clocks/line); H_SYNC 96 (hsync width, clocks); H_BP 48 (back porch); H_ACTIVE 640; V_TOTAL 525 (lines/frame); V_SYNC 2 (vsync width, lines); V_BP 33; V_ACTIVE 480; SYNC_POL 0 (0 = syncs active-low).
REQ-002 SHALL have ports: clk  in  1  pixel clock, single clock domain.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 hsync_in  in  1  horizontal sync under test.
REQ-005 vsync_in  in  1  vertical sync under test.
REQ-006 red_in, green_in, blue_in  in  8 each  pixel colour.
REQ-007 err_clr  in  1  clears sticky error flags.
REQ-008 locked  out  1  timing verified, pixel stream valid.
REQ-009 h_err, v_err  out  1 each  sticky horizontal/vertical timing error.
REQ-010 frame_done  out  1  one-cycle pulse at end of a good locked frame.
REQ-011 frame_count  out  16  good frames since reset, wraps.
REQ-012 pix_valid  out  1; pix_x  out  10; pix_y  out  10; pix_rgb  out  24 {r,g,b}.
REQ-013 frame_sum  out  16  per-frame colour checksum (see Configuration).

Function
REQ-014 Syncs and colour SHALL be registered twice; edge detect on the two stages; "asserted" means level == SYNC_POL.
REQ-015 hcnt (12 b) SHALL load 0 on the hsync assert edge, else increment, saturating at 4095.
REQ-016 At each hsync assert edge, period hcnt+1 SHALL equal H_TOTAL; at each hsync deassert edge, asserted-cycle count SHALL equal H_SYNC; mismatch = horizontal error.
REQ-017 vcnt (11 b) SHALL load 0 on the vsync assert edge, else increment on each hsync assert edge, saturating.
REQ-018 At vsync assert edge, vcnt+1 SHALL equal V_TOTAL; hsync assert edges while vsync asserted SHALL equal V_SYNC; mismatch = vertical error.
REQ-019 FSM states SEARCH, ACQUIRE, LOCKED; SEARCH->ACQUIRE on first vsync assert edge; ACQUIRE->LOCKED on next vsync assert edge if no error since entry, else remain ACQUIRE with error history cleared.
REQ-020 In LOCKED any error SHALL set the matching sticky flag, deassert locked the next cycle, and move to ACQUIRE; errors in SEARCH/ACQUIRE SHALL NOT set sticky flags.
REQ-021 err_clr SHALL clear h_err/v_err; a new error in the same cycle SHALL win (flag stays 1).
REQ-022 pix_valid SHALL be 1 only when locked and H_SYNC+H_BP <= hcnt < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= vcnt < V_SYNC+V_BP+V_ACTIVE.
REQ-023 pix_x = hcnt-(H_SYNC+H_BP), pix_y = vcnt-(V_SYNC+V_BP) when valid, else 0; pix_rgb = input colour delayed to align; all pixel outputs registered, latency 3 clocks from input pins.
REQ-024 frame_done SHALL pulse and frame_count increment (mod 2^16) on a vsync assert edge in LOCKED with no error in that frame; not on the ACQUIRE->LOCKED transition.

Reset
REQ-025 On reset, FSM = SEARCH, counters = 0, locked, h_err, v_err, frame_done, pix_valid = 0, pix_x, pix_y, pix_rgb, frame_count, frame_sum = 0.
REQ-026 Reset mid-frame SHALL discard all partial measurements; relock requires a vsync edge plus one full clean frame.

Configuration
REQ-027 With VGA_MON_CHECKSUM_EN defined: accumulator adds r+g+b per valid pixel mod 2^16, latched into frame_sum on frame_done, then cleared; also cleared on leaving LOCKED.
REQ-028 Without VGA_MON_CHECKSUM_EN: no accumulator; frame_sum tied to 0.

Verification
REQ-029 Ideal 640x480 generator from reset -> locked rises after second vsync assert edge; 307200 pix_valid cycles per locked frame; frame_done once per frame.
REQ-030 Locked; one line with period 799 -> h_err=1, locked=0 within 1 clock; one clean frame later locked=1, h_err stays 1 until err_clr.
REQ-031 Locked; frame with 524 lines -> v_err=1, no frame_done for that frame, frame_count unchanged.
REQ-032 err_clr pulsed in the same cycle as an hsync width error (95) -> h_err remains 1.
REQ-033 Reset asserted at line 200 -> all outputs 0 next cycle; relock after two vsync edges.
REQ-034 Checksum build, constant r=1,g=2,b=3 -> frame_sum=0x2000 each locked frame; non-checksum build -> frame_sum=0.

Source files
------------

// File: rtl/vga_frame_monitor.sv
// -----------------------------------------------------------------------------
// vga_frame_monitor
//
// Purpose:
//   Watches an incoming VGA-style sync/colour stream and checks the hsync and
//   vsync timing against the parameterised mode. Once two consecutive vsync
//   edges enclose a clean frame, the monitor reports lock. While locked it
//   produces an aligned pixel stream (valid/x/y/rgb) and counts good frames.
//   Timing errors seen while locked are recorded in sticky flags.
//
// Parameters:
//   H_TOTAL, H_SYNC, H_BP, H_ACTIVE : line timing in pixel clocks
//   V_TOTAL, V_SYNC, V_BP, V_ACTIVE : frame timing in lines
//   SYNC_POL                        : asserted sync level (0 = active-low)
//
// Ports:
//   clk                      pixel clock, the only clock domain
//   reset                    synchronous, active-high
//   hsync_in, vsync_in       syncs under test
//   red_in/green_in/blue_in  8-bit colour
//   err_clr                  clears h_err/v_err (a same-cycle new error wins)
//   locked                   timing verified, pixel stream valid
//   h_err, v_err             sticky horizontal/vertical timing errors
//   frame_done               one-cycle pulse at the end of a good locked frame
//   frame_count              good frames since reset (wraps)
//   pix_valid/pix_x/pix_y    active-area pixel position, 3 clocks after pins
//   pix_rgb                  {r,g,b} aligned with pix_x/pix_y
//   frame_sum                per-frame colour checksum
//
// Optional feature:
//   Define VGA_MON_CHECKSUM_EN to build the colour checksum accumulator.
//   Without it frame_sum is tied to zero.
// -----------------------------------------------------------------------------
module vga_frame_monitor #(
  parameter int   H_TOTAL  = 800,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   H_ACTIVE = 640,
  parameter int   V_TOTAL  = 525,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   V_ACTIVE = 480,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [7:0]  red_in,
  input  logic [7:0]  green_in,
  input  logic [7:0]  blue_in,
  input  logic        err_clr,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic [15:0] frame_sum
);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_e;

  // Counters hold "cycles/lines since the last assert edge minus one", so each
  // check compares against the nominal value minus one.
  localparam logic [11:0] H_TOTAL_M1 = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_SYNC_M1  = 12'(H_SYNC - 1);
  localparam logic [11:0] H_START    = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_END      = 12'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] V_TOTAL_M1 = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_SYNC_M1  = 11'(V_SYNC - 1);
  localparam logic [10:0] V_START    = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_END      = 11'(V_SYNC + V_BP + V_ACTIVE);

  // Input double-register stages; the edge detectors compare the two stages.
  logic        hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q;
  logic [23:0] rgb_s1_q, rgb_s2_q;

  logic [11:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;
  logic        h_seen_q, h_seen_d, v_seen_q, v_seen_d;
  logic        hist_q, hist_d;
  state_e      state_q, state_d;
  logic        locked_q, locked_d;
  logic        h_err_q, h_err_d, v_err_q, v_err_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        pix_valid_q, pix_valid_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [23:0] pix_rgb_q, pix_rgb_d;

  logic h_rise, h_fall, v_rise, v_fall;
  logic h_bad, v_bad, any_bad, in_win;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    h_rise = (hs_s1_q == SYNC_POL) && (hs_s2_q != SYNC_POL);
    h_fall = (hs_s1_q != SYNC_POL) && (hs_s2_q == SYNC_POL);
    v_rise = (vs_s1_q == SYNC_POL) && (vs_s2_q != SYNC_POL);
    v_fall = (vs_s1_q != SYNC_POL) && (vs_s2_q == SYNC_POL);

    hcnt_d = h_rise ? '0 : ((hcnt_q == 12'hFFF) ? hcnt_q : hcnt_q + 12'd1);
    vcnt_d = vcnt_q;
    if (v_rise)                         vcnt_d = '0;
    else if (h_rise && vcnt_q != '1)    vcnt_d = vcnt_q + 11'd1;

    // Measurements are only meaningful once the counter has been anchored by
    // an assert edge; before that the count is partial and is ignored.
    h_seen_d = h_seen_q | h_rise;
    v_seen_d = v_seen_q | v_rise;
    h_bad    = h_seen_q && ((h_rise && hcnt_q != H_TOTAL_M1) ||
                            (h_fall && hcnt_q != H_SYNC_M1));
    v_bad    = v_seen_q && ((v_rise && vcnt_q != V_TOTAL_M1) ||
                            (v_fall && vcnt_q != V_SYNC_M1));
    any_bad  = h_bad | v_bad;

    state_d       = state_q;
    hist_d        = hist_q | any_bad;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    h_err_d       = err_clr ? 1'b0 : h_err_q;
    v_err_d       = err_clr ? 1'b0 : v_err_q;

    case (state_q)
      SEARCH: begin
        if (v_rise) begin
          state_d = ACQUIRE;
          hist_d  = 1'b0;
        end
      end
      ACQUIRE: begin
        // Errors in the closing cycle belong to the frame just finished.
        if (v_rise) begin
          hist_d = 1'b0;
          if (!(hist_q || any_bad)) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (any_bad) begin
          state_d = ACQUIRE;
          hist_d  = 1'b0;
          if (h_bad) h_err_d = 1'b1;
          if (v_bad) v_err_d = 1'b1;
        end else if (v_rise) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end
      end
      default: state_d = SEARCH;
    endcase

    locked_d = (state_d == LOCKED);

    in_win = locked_q &&
             (hcnt_q >= H_START) && (hcnt_q < H_END) &&
             (vcnt_q >= V_START) && (vcnt_q < V_END);
    pix_valid_d = in_win;
    pix_x_d     = in_win ? 10'(hcnt_q - H_START) : '0;
    pix_y_d     = in_win ? 10'(vcnt_q - V_START) : '0;
    pix_rgb_d   = rgb_s2_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only; it is part of the
    // synchronous next-state logic, not an asynchronous clear.
    if (reset) begin
      hs_s1_q       <= ~SYNC_POL;
      hs_s2_q       <= ~SYNC_POL;
      vs_s1_q       <= ~SYNC_POL;
      vs_s2_q       <= ~SYNC_POL;
      rgb_s1_q      <= '0;
      rgb_s2_q      <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      h_seen_q      <= 1'b0;
      v_seen_q      <= 1'b0;
      hist_q        <= 1'b0;
      state_q       <= SEARCH;
      locked_q      <= 1'b0;
      h_err_q       <= 1'b0;
      v_err_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // value of its source, which is what makes the s1->s2 pipe a pipe.
      hs_s1_q       <= hsync_in;
      hs_s2_q       <= hs_s1_q;
      vs_s1_q       <= vsync_in;
      vs_s2_q       <= vs_s1_q;
      rgb_s1_q      <= {red_in, green_in, blue_in};
      rgb_s2_q      <= rgb_s1_q;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      h_seen_q      <= h_seen_d;
      v_seen_q      <= v_seen_d;
      hist_q        <= hist_d;
      state_q       <= state_d;
      locked_q      <= locked_d;
      h_err_q       <= h_err_d;
      v_err_q       <= v_err_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_rgb_q     <= pix_rgb_d;
    end
  end

`ifdef VGA_MON_CHECKSUM_EN
  logic [15:0] acc_q, acc_d, sum_q, sum_d;

  always_comb begin
    acc_d = acc_q;
    sum_d = sum_q;
    if (in_win) acc_d = acc_q + 16'(rgb_s2_q[23:16]) + 16'(rgb_s2_q[15:8]) +
                        16'(rgb_s2_q[7:0]);
    if (frame_done_d) begin
      sum_d = acc_q;
      acc_d = '0;
    end
    // A frame interrupted by loss of lock must not leak into the next sum.
    if (state_q == LOCKED && state_d != LOCKED) acc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      acc_q <= acc_d;
      sum_q <= sum_d;
    end
  end

  assign frame_sum = sum_q;
`else
  assign frame_sum = '0;
`endif

  assign locked      = locked_q;
  assign h_err       = h_err_q;
  assign v_err       = v_err_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_rgb     = pix_rgb_q;

endmodule
